// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_t;

  localparam int DB_STABLE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs.
module sync_2ff (
  input  logic Clk,
  input  logic Rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state always uses non-blocking assignments so flops update together.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// Debounces Btn into a clean level D with one-cycle En/Rise/Fall strobes.
// Define BUTTON_DEBOUNCER_SYNC2_EN to use a two-flop input synchronizer.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
  parameter int CNT_W         = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Btn,
  output logic D,
  output logic En,
  output logic Rise,
  output logic Fall,
  output logic Busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_s;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             r_d, r_en, r_rise, r_fall, r_busy;

`ifdef BUTTON_DEBOUNCER_SYNC2_EN
  sync_2ff u_sync (
    .Clk (Clk),
    .Rst (Rst),
    .i_d (Btn),
    .o_q (w_s)
  );
`else
  logic r_s;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_s <= 1'b0;
    else     r_s <= Btn;
  end

  assign w_s = r_s;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A sample equal to D in a PEND state drops back and restarts the count.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_accept    = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (w_s) begin
          w_state_nxt = PEND_HI;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      PEND_HI: begin
        if (!w_s) begin
          w_state_nxt = STABLE_LO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!w_s) begin
          w_state_nxt = PEND_LO;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      PEND_LO: begin
        if (w_s) begin
          w_state_nxt = STABLE_HI;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_LO;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = STABLE_LO;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_d    <= 1'b0;
      r_en   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_d    <= (w_state_nxt == STABLE_HI) || (w_state_nxt == PEND_LO);
      r_en   <= w_accept;
      r_rise <= w_accept && (w_state_nxt == STABLE_HI);
      r_fall <= w_accept && (w_state_nxt == STABLE_LO);
      r_busy <= (w_state_nxt == PEND_HI) || (w_state_nxt == PEND_LO);
    end
  end

  assign D    = r_d;
  assign En   = r_en;
  assign Rise = r_rise;
  assign Fall = r_fall;
  assign Busy = r_busy;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: expected {D,En,Rise,Fall,Busy} per cycle.
module tb_button_debouncer;

  logic Clk = 1'b0;
  logic Rst;
  logic Btn;
  logic D, En, Rise, Fall, Busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit seg_start;

  logic [4:0] exp_q[$];

  button_debouncer #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .Btn  (Btn),
    .D    (D),
    .En   (En),
    .Rise (Rise),
    .Fall (Fall),
    .Busy (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are compared 1 time unit after every rising edge.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cyc%0d {D,En,Rise,Fall,Busy}", cyc), {27'd0, D, En, Rise, Fall, Busy}, {27'd0, e});
      end
    end
  end

  // One stimulus cycle: drive Btn and queue the outputs expected after the next edge.
  task automatic step(input logic b, input logic [4:0] exp);
    @(posedge Clk);
    #2;
    Btn = b;
`ifdef BUTTON_DEBOUNCER_SYNC2_EN
    if (seg_start) exp_q.push_back(5'b00000);
`endif
    seg_start = 1'b0;
    exp_q.push_back(exp);
  endtask

  task automatic rise_seq();
    step(1'b1, 5'b00000);
    repeat (3) step(1'b1, 5'b00001);
    step(1'b1, 5'b11100);
    repeat (2) step(1'b1, 5'b10000);
  endtask

  task automatic fall_seq();
    step(1'b0, 5'b10000);
    repeat (3) step(1'b0, 5'b10001);
    step(1'b0, 5'b01010);
    repeat (2) step(1'b0, 5'b00000);
  endtask

  // Assert reset between edges, confirm outputs clear at once, then release.
  task automatic mid_reset(input string name, input logic b);
    @(posedge Clk);
    #4;
    Rst = 1'b1;
    Btn = b;
    #1;
    check(name, {27'd0, D, En, Rise, Fall, Busy}, 32'd0);
    exp_q.delete();
    @(posedge Clk);
    #2;
    Rst = 1'b0;
    seg_start = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1;
    Btn = 1'b0;
    #1;
    check("reset_state", {27'd0, D, En, Rise, Fall, Busy}, 32'd0);
    @(posedge Clk);
    #2;
    Rst = 1'b0;
    seg_start = 1'b1;

    // Idle low: nothing moves.
    repeat (10) step(1'b0, 5'b00000);

    // Clean press held 10 cycles, then clean release.
    step(1'b1, 5'b00000);
    repeat (3) step(1'b1, 5'b00001);
    step(1'b1, 5'b11100);
    repeat (5) step(1'b1, 5'b10000);
    fall_seq();

    // Two-cycle glitch: Busy pulses, no strobe.
    step(1'b1, 5'b00000);
    step(1'b1, 5'b00001);
    step(1'b0, 5'b00001);
    repeat (4) step(1'b0, 5'b00000);

    // Bounce 1,0,1,1,0,1,1,1,1 then held: only the last run is accepted.
    step(1'b1, 5'b00000);
    step(1'b0, 5'b00001);
    step(1'b1, 5'b00000);
    step(1'b1, 5'b00001);
    step(1'b0, 5'b00001);
    step(1'b1, 5'b00000);
    step(1'b1, 5'b00001);
    step(1'b1, 5'b00001);
    step(1'b1, 5'b00001);
    step(1'b1, 5'b11100);
    step(1'b1, 5'b10000);
    step(1'b1, 5'b10000);
    fall_seq();

    // Reset inside PEND_HI: pending rise discarded, nothing after release.
    step(1'b1, 5'b00000);
    step(1'b1, 5'b00001);
    step(1'b1, 5'b00001);
    mid_reset("rst_in_pend_hi", 1'b0);
    repeat (6) step(1'b0, 5'b00000);

    // Reset inside PEND_LO with D=1, released with Btn=1: D clears, then a normal rise.
    rise_seq();
    step(1'b0, 5'b10000);
    step(1'b0, 5'b10001);
    step(1'b0, 5'b10001);
    mid_reset("rst_in_pend_lo", 1'b1);
    repeat (3) step(1'b1, 5'b00001);
    step(1'b1, 5'b11100);
    repeat (2) step(1'b1, 5'b10000);
    fall_seq();

    repeat (3) @(posedge Clk);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
